// File: rtl/bus_mem_slave.sv
// bus_mem_slave: strobed word-memory responder with programmable wait states.
// Answers one read/write per strobe; drives the shared bus only in a read ACK.
module bus_mem_slave #(
    parameter int ADDR_SIZE   = 8,
    parameter int WORD_SIZE   = 16,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic                 rw,
    input  logic                 strb,
    inout  logic [WORD_SIZE-1:0] data,
    output logic                 rdy,
    output logic                 busy,
    output logic                 err
);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t state, state_n;
    logic [3:0] cnt;
    logic [ADDR_SIZE-1:0] a_l, a_n;
    logic rw_l, start, enter_ack, in_range, in_range_n;
    logic [WORD_SIZE-1:0] rd_q;
    logic [WORD_SIZE-1:0] mem [DEPTH];

    assign start      = state == IDLE && !strb;
    assign a_n        = start ? addr : a_l;
    assign in_range   = int'(a_l) < DEPTH;
    assign in_range_n = int'(a_n) < DEPTH;
    assign enter_ack  = state_n == ACK && state != ACK;

    always_comb begin
        state_n = state;
        state_n = start ? (WAIT_STATES == 0 ? ACK : WAIT) :
                  state == WAIT ? (cnt == 4'd1 ? ACK : WAIT) :
                  state == ACK ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            a_l   <= '0;
            rw_l  <= 1'b0;
            err   <= 1'b0;
            rd_q  <= '0;
        end else begin
            state <= state_n;
            if (start) begin
                a_l  <= addr;
                rw_l <= rw;
                cnt  <= 4'(WAIT_STATES);
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            // strobe while busy, or out-of-range access flagged during ACK
            err <= (state != IDLE && !strb) || (enter_ack && !in_range_n);
            if (enter_ack)
                rd_q <= in_range_n ? mem[a_n[IW-1:0]] : '1;
        end
    end

    // contents survive reset; a reset at the closing edge cancels the write
    always_ff @(posedge clk) begin
        if (!rst && state == ACK && !rw_l && in_range)
            mem[a_l[IW-1:0]] <= data;
    end

    assign rdy  = state != ACK;
    assign busy = state != IDLE;
    assign data = (state == ACK && rw_l) ? rd_q : 'z;
endmodule

// File: tb/tb_bus_mem_slave.sv
// tb_bus_mem_slave: random and directed transfers on two slave configurations,
// checked against an array model of memory contents and transfer timing.
module tb_bus_mem_slave;
    localparam int WS[2]  = '{0, 3};
    localparam int DEP[2] = '{256, 16};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] addr_v [2];
    logic rw_v [2];
    logic strb_v [2];
    logic den [2];
    logic [15:0] dval [2];
    logic rdy_v [2];
    logic busy_v [2];
    logic err_v [2];
    wire [15:0] data0, data1;
    logic [15:0] ref_mem [2][256];
    int rdy_cnt [2] = '{0, 0};
    int err_cnt [2] = '{0, 0};
    int n_vec = 0, n_bad = 0;

    always #5 clk = ~clk;

    assign data0 = den[0] ? dval[0] : 'z;
    assign data1 = den[1] ? dval[1] : 'z;

    bus_mem_slave #(.WAIT_STATES(0), .DEPTH(256)) u0 (
        .clk(clk), .rst(rst), .addr(addr_v[0]), .rw(rw_v[0]), .strb(strb_v[0]),
        .data(data0), .rdy(rdy_v[0]), .busy(busy_v[0]), .err(err_v[0])
    );

    bus_mem_slave #(.WAIT_STATES(3), .DEPTH(16)) u1 (
        .clk(clk), .rst(rst), .addr(addr_v[1]), .rw(rw_v[1]), .strb(strb_v[1]),
        .data(data1), .rdy(rdy_v[1]), .busy(busy_v[1]), .err(err_v[1])
    );

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rdy_v[i]) rdy_cnt[i] <= rdy_cnt[i] + 1;
            if (err_v[i]) err_cnt[i] <= err_cnt[i] + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] bus(input int s);
        return s != 0 ? data1 : data0;
    endfunction

    // one transfer; dbl re-strobes mid-WAIT, settle checks pulse counts afterwards
    task automatic xfer(input int s, input bit r, input logic [7:0] a, input logic [15:0] wd,
                        input bit dbl, input bit settle);
        int lat, rc, ec;
        bit oor, seen;
        logic [15:0] exp;
        oor = int'(a) >= DEP[s];
        exp = oor ? 16'hffff : ref_mem[s][a];
        rc = rdy_cnt[s];
        ec = err_cnt[s];
        @(negedge clk);
        addr_v[s] = a;
        rw_v[s]   = r;
        strb_v[s] = 1'b0;
        den[s]    = !r;
        dval[s]   = wd;
        seen = 0;
        lat  = 0;
        for (int n = 1; n <= 20 && !seen; n++) begin
            @(negedge clk);
            strb_v[s] = !(dbl && n == 2);
            if (!rdy_v[s]) begin
                seen = 1;
                lat  = n;
                chk("ack_busy", busy_v[s], 1);
                if (r) chk("rdata", bus(s), exp);
                else   chk("wbus", bus(s), wd);
            end
        end
        chk("latency", lat, 1 + WS[s]);
        if (!r && !oor) ref_mem[s][a] = wd;
        if (settle) begin
            repeat (2) @(negedge clk);
            chk("rdy_pulses", rdy_cnt[s] - rc, 1);
            chk("err_pulses", err_cnt[s] - ec, 32'(oor) + 32'(dbl));
            chk("idle_busy", busy_v[s], 0);
            chk("idle_rdy", rdy_v[s], 1);
        end
    endtask

    initial begin
        int rc, ec;
        time t0;
        for (int i = 0; i < 2; i++) begin
            strb_v[i] = 1'b1;
            rw_v[i]   = 1'b1;
            addr_v[i] = '0;
            den[i]    = 1'b0;
            dval[i]   = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_rdy", rdy_v[i], 1);
            chk("rst_busy", busy_v[i], 0);
            chk("rst_err", err_v[i], 0);
        end
        rst = 1'b0;

        for (int s = 0; s < 2; s++)
            for (int a = 0; a < DEP[s]; a++) xfer(s, 0, 8'(a), 16'(a), 0, 1);
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 10; a++) xfer(s, 1, 8'(a), 16'h0, 0, 1);

        xfer(1, 0, 8'h0b, 16'hbeef, 0, 1);
        xfer(1, 1, 8'h0b, 16'h0, 0, 1);
        xfer(1, 0, 8'h20, 16'h1234, 0, 1);
        xfer(1, 1, 8'h20, 16'h0, 0, 1);
        xfer(1, 1, 8'h00, 16'h0, 0, 1);
        xfer(1, 1, 8'h0b, 16'h0, 1, 1);

        rc = rdy_cnt[1];
        @(negedge clk);
        addr_v[1] = 8'h07;
        rw_v[1]   = 1'b0;
        strb_v[1] = 1'b0;
        den[1]    = 1'b1;
        dval[1]   = 16'h5555;
        @(negedge clk);
        strb_v[1] = 1'b1;
        chk("mid_busy", busy_v[1], 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy_v[1], 0);
        chk("abort_rdy", rdy_v[1], 1);
        rst = 1'b0;
        den[1] = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_no_rdy", rdy_cnt[1] - rc, 0);
        xfer(1, 1, 8'h07, 16'h0, 0, 1);

        rc = rdy_cnt[0];
        ec = err_cnt[0];
        t0 = $time;
        for (int i = 0; i < 20; i++) begin
            logic [7:0] a;
            a = 8'($urandom_range(0, 255));
            xfer(0, 0, a, 16'($urandom), 0, 0);
            xfer(0, 1, a, 16'h0, 0, 0);
        end
        chk("b2b_cycles", 32'(($time - t0) / 10), 80);
        repeat (2) @(negedge clk);
        chk("b2b_rdy", rdy_cnt[0] - rc, 40);
        chk("b2b_err", err_cnt[0] - ec, 0);

        for (int i = 0; i < 150; i++) begin
            int s;
            s = int'($urandom_range(0, 1));
            xfer(s, 1'($urandom_range(0, 1)),
                 8'(s != 0 ? $urandom_range(0, 31) : $urandom_range(0, 255)),
                 16'($urandom), s != 0 && $urandom_range(0, 3) == 0, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
